// File: rtl/silu_pipe.sv
// Four-stage, multi-lane SiLU / sigmoid unit using a piecewise-quadratic sigmoid.
// All lanes share one valid/ready handshake; the whole pipeline stalls as a unit.
module silu_pipe #(
   parameter int unsigned IL    = 4,
   parameter int unsigned FL    = 16,
   parameter int unsigned LANES = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        mode,
   input  logic [LANES*(IL+FL)-1:0]    i,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_mode,
   output logic [LANES*(IL+FL)-1:0]    f
);

   localparam int unsigned W   = IL + FL;
   localparam int unsigned AW  = FL + 3;
   localparam int unsigned TW  = FL + 1;
   localparam int unsigned SQW = 2 * TW;
   localparam int unsigned PW  = W + TW + 1;

   localparam logic [W:0]    FOUR = {{(IL-2){1'b0}}, 1'b1, {(FL+2){1'b0}}};
   localparam logic [TW-1:0] ONE  = {1'b1, {FL{1'b0}}};

   logic                          advance;
   logic                          v1, v2, v3, v4;
   logic                          s1_mode, s2_mode, s3_mode, s4_mode;

   logic [LANES-1:0][W-1:0]       xin, s1_x, s2_x, s3_x, s4_f;
   logic [LANES-1:0][TW-1:0]      n1_q, s1_q;
   logic [LANES-1:0][SQW-1:0]     n2_sq, s2_sq;
   logic [LANES-1:0][TW-1:0]      n3_sig, s3_sig;
   logic [LANES-1:0][PW-1:0]      n4_p;
   logic [LANES-1:0][W-1:0]       n4_f;

   logic [W:0]                    xe, ax;
   logic [TW-1:0]                 t;
   logic [PW-1:0]                 px, ps;
   logic                          unused;

   assign xin       = i;
   assign f         = s4_f;
   assign out_valid = v4;
   assign out_mode  = s4_mode;
   assign advance   = !v4 || out_ready;
   assign in_ready  = advance;

   // S1 keeps a/4 rather than a: the clamp and the quarter are folded together,
   // since only the quarter is consumed downstream.
   always_comb begin
      xe   = '0;
      ax   = '0;
      n1_q = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         xe      = {xin[k][W-1], xin[k]};
         ax      = xin[k][W-1] ? ('0 - xe) : xe;
         n1_q[k] = (ax > FOUR) ? FOUR[AW-1:2] : ax[AW-1:2];
      end
   end

   always_comb begin
      t     = '0;
      n2_sq = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         t        = ONE - s1_q[k];
         n2_sq[k] = {{TW{1'b0}}, t} * {{TW{1'b0}}, t};
      end
   end

   // s = t^2 / 2 truncated to FL fraction bits is the top TW bits of the square.
   always_comb begin
      n3_sig = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         n3_sig[k] = s2_x[k][W-1] ? s2_sq[k][SQW-1:FL+1]
                                  : ONE - s2_sq[k][SQW-1:FL+1];
      end
   end

   always_comb begin
      px   = '0;
      ps   = '0;
      n4_p = '0;
      n4_f = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         px      = {{(TW+1){s3_x[k][W-1]}}, s3_x[k]};
         ps      = {{(W+1){1'b0}}, s3_sig[k]};
         n4_p[k] = px * ps;
         n4_f[k] = s3_mode ? {{(W-TW){1'b0}}, s3_sig[k]} : n4_p[k][FL +: W];
      end
   end

   assign unused = ^{s2_sq, n4_p};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
      end else if (advance) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q    <= '0;
         s1_x    <= '0;
         s1_mode <= 1'b0;
      end else if (advance && in_valid) begin
         s1_q    <= n1_q;
         s1_x    <= xin;
         s1_mode <= mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_sq   <= '0;
         s2_x    <= '0;
         s2_mode <= 1'b0;
      end else if (advance && v1) begin
         s2_sq   <= n2_sq;
         s2_x    <= s1_x;
         s2_mode <= s1_mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s3_sig  <= '0;
         s3_x    <= '0;
         s3_mode <= 1'b0;
      end else if (advance && v2) begin
         s3_sig  <= n3_sig;
         s3_x    <= s2_x;
         s3_mode <= s2_mode;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s4_f    <= '0;
         s4_mode <= 1'b0;
      end else if (advance && v3) begin
         s4_f    <= n4_f;
         s4_mode <= s3_mode;
      end
   end

endmodule

// File: tb/tb_silu_pipe.sv
// Self-checking bench for silu_pipe: directed spec vectors plus a scoreboard
// fed by an arithmetic model of the piecewise-quadratic SiLU / sigmoid.
module tb_silu_pipe;

   localparam int IL    = 4;
   localparam int FL    = 16;
   localparam int LANES = 4;
   localparam int W     = IL + FL;
   localparam int LW    = LANES * W;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          mode = 1'b0;
   logic [LW-1:0] i = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_mode;
   logic [LW-1:0] f;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [LW-1:0] f;
      logic          m;
   } exp_t;
   exp_t exp_q[$];

   silu_pipe #(.IL(IL), .FL(FL), .LANES(LANES)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .i(i), .out_valid(out_valid), .out_ready(out_ready),
      .out_mode(out_mode), .f(f)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] gold(input logic [W-1:0] x, input logic m);
      longint xv, ax, a, t, s, sig, p;
      xv  = longint'($signed(x));
      ax  = (xv < 0) ? -xv : xv;
      a   = (ax > 262144) ? 262144 : ax;
      t   = 65536 - (a >> 2);
      s   = (t * t) >> 17;
      sig = (xv >= 0) ? 65536 - s : s;
      p   = m ? sig : ((xv * sig) >>> 16);
      return p[W-1:0];
   endfunction

   function automatic logic [LW-1:0] gold_vec(input logic [LW-1:0] d, input logic m);
      logic [LW-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++) r[k*W +: W] = gold(d[k*W +: W], m);
      return r;
   endfunction

   // One clock of stimulus; returns what was observed mid-cycle.
   task automatic step(input logic iv, input logic [LW-1:0] d, input logic m, input logic ordy,
                       output logic acc, output logic fire, output logic ov, output logic ir,
                       output logic [LW-1:0] of, output logic om, output int c);
      in_valid  = iv;
      i         = d;
      mode      = m;
      out_ready = ordy;
      @(negedge clk);
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      ov   = out_valid;
      ir   = in_ready;
      of   = f;
      om   = out_mode;
      c    = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic acc, fire, ov, ir, om;
      logic [LW-1:0] of;
      int c;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (f !== '0) begin errors++; $display("FAIL reset_f got=%h exp=0", f); end
      checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode got=%b exp=0", out_mode); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      reset = 1'b1;
      step(1'b0, '0, 1'b0, 1'b1, acc, fire, ov, ir, of, om, c);
      checks++; if (ir !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", ir, ov); end
   endtask

   task automatic test_single_beat(input string name, input logic [LW-1:0] d,
                                   input logic m, input logic [LW-1:0] expf);
      logic acc, fire, ov, ir, om;
      logic [LW-1:0] of;
      int c, c0, got;
      exp_t e;
      step(1'b1, d, m, 1'b1, acc, fire, ov, ir, of, om, c0);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b exp=1", name, acc); end
      else exp_q.push_back('{f: expf, m: m});
      got = 0;
      for (int n = 0; n < 12; n++) begin
         step(1'b0, '0, 1'b0, 1'b1, acc, fire, ov, ir, of, om, c);
         if (fire) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL %s_extra_beat got f=%h", name, of);
            end else begin
               e = exp_q.pop_front();
               if (of !== e.f || om !== e.m) begin
                  errors++; $display("FAIL %s_data got f=%h mode=%b exp f=%h mode=%b", name, of, om, e.f, e.m);
               end
               checks++;
               if (c - c0 != 4) begin errors++; $display("FAIL %s_latency got=%0d exp=4", name, c - c0); end
            end
         end
      end
      checks++;
      if (got != 1) begin errors++; $display("FAIL %s_beat_count got=%0d exp=1", name, got); end
      exp_q.delete();
   endtask

   task automatic test_stream;
      logic acc, fire, ov, ir, om, m, pstall, pm;
      logic [LW-1:0] of, pf;
      logic [LW-1:0] beats[16];
      int c, sent, rcvd, v;
      exp_t e;
      for (int b = 0; b < 16; b++)
         for (int k = 0; k < LANES; k++) begin
            v = (k < 2) ? int'($urandom_range(0, 32'hFFFFF)) : int'($urandom_range(0, 524288)) - 262144;
            beats[b][k*W +: W] = v[W-1:0];
         end
      beats[3][W-1:0] = 20'h80000;
      beats[5][W-1:0] = 20'h7FFFF;
      sent = 0; rcvd = 0; pstall = 1'b0; pf = '0; pm = 1'b0;
      for (int n = 0; n < 400 && (sent < 16 || rcvd < 16); n++) begin
         m = sent[0];
         step(sent < 16, (sent < 16) ? beats[sent % 16] : '0, m, 1'($urandom_range(0, 1)),
              acc, fire, ov, ir, of, om, c);
         if (pstall) begin
            checks++;
            if (of !== pf || om !== pm) begin
               errors++; $display("FAIL stream_stall_hold got f=%h mode=%b exp f=%h mode=%b", of, om, pf, pm);
            end
         end
         pstall = ov && !out_ready;
         pf = of; pm = om;
         if (fire) begin
            rcvd++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stream_unexpected got f=%h", of);
            end else begin
               e = exp_q.pop_front();
               if (of !== e.f || om !== e.m) begin
                  errors++; $display("FAIL stream_data got f=%h mode=%b exp f=%h mode=%b", of, om, e.f, e.m);
               end
            end
         end
         if (acc) begin
            exp_q.push_back('{f: gold_vec(beats[sent % 16], m), m: m});
            sent++;
         end
      end
      checks++;
      if (rcvd != 16 || sent != 16 || exp_q.size() != 0) begin
         errors++; $display("FAIL stream_count got sent=%0d rcvd=%0d pending=%0d exp 16/16/0", sent, rcvd, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_flight;
      logic acc, fire, ov, ir, om;
      logic [LW-1:0] of, d;
      int c, stale;
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < LANES; k++) d[k*W +: W] = W'($urandom);
         step(1'b1, d, 1'b1, 1'b0, acc, fire, ov, ir, of, om, c);
         checks++;
         if (acc !== 1'b1) begin errors++; $display("FAIL flight_accept beat=%0d got=%b exp=1", b, acc); end
         else exp_q.push_back('{f: gold_vec(d, 1'b1), m: 1'b1});
      end
      step(1'b0, '0, 1'b0, 1'b0, acc, fire, ov, ir, of, om, c);
      step(1'b0, '0, 1'b0, 1'b0, acc, fire, ov, ir, of, om, c);
      checks++;
      if (ov !== 1'b1 || ir !== 1'b0) begin errors++; $display("FAIL flight_stalled got out_valid=%b in_ready=%b exp 1/0", ov, ir); end
      #2 reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_async_valid got=%b exp=0", out_valid); end
      checks++; if (f !== '0) begin errors++; $display("FAIL flight_async_f got=%h exp=0", f); end
      checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL flight_async_mode got=%b exp=0", out_mode); end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_release_ready got=%b exp=1", in_ready); end
      stale = 0;
      for (int n = 0; n < 12; n++) begin
         step(1'b0, '0, 1'b0, 1'b1, acc, fire, ov, ir, of, om, c);
         if (ov) stale++;
      end
      checks++;
      if (stale != 0) begin errors++; $display("FAIL flight_stale got=%0d beats exp=0", stale); end
   endtask

   task automatic test_throughput;
      logic acc, fire, ov, ir, om, iv, m;
      logic [LW-1:0] of, d;
      int c, sent, rcvd, drops, extra, cin, cout;
      exp_t e;
      sent = 0; rcvd = 0; drops = 0; extra = 0; cin = -1; cout = -1;
      for (int n = 0; n < 300 && rcvd < 100; n++) begin
         iv = (sent < 100);
         m  = sent[0];
         for (int k = 0; k < LANES; k++) d[k*W +: W] = W'($urandom);
         step(iv, d, m, 1'b1, acc, fire, ov, ir, of, om, c);
         if (iv && !ir) drops++;
         if (fire) begin
            if (cout < 0) cout = c;
            rcvd++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL tp_unexpected got f=%h", of);
            end else begin
               e = exp_q.pop_front();
               if (of !== e.f || om !== e.m) begin
                  errors++; $display("FAIL tp_data got f=%h mode=%b exp f=%h mode=%b", of, om, e.f, e.m);
               end
            end
         end
         if (acc) begin
            if (cin < 0) cin = c;
            exp_q.push_back('{f: gold_vec(d, m), m: m});
            sent++;
         end
      end
      for (int n = 0; n < 6; n++) begin
         step(1'b0, '0, 1'b0, 1'b1, acc, fire, ov, ir, of, om, c);
         if (fire) extra++;
      end
      checks++; if (drops != 0) begin errors++; $display("FAIL tp_in_ready_drops got=%0d exp=0", drops); end
      checks++; if (rcvd != 100 || extra != 0) begin errors++; $display("FAIL tp_count got=%0d extra=%0d exp 100/0", rcvd, extra); end
      checks++; if (cout - cin != 4) begin errors++; $display("FAIL tp_first_latency got=%0d exp=4", cout - cin); end
      exp_q.delete();
   endtask

   initial begin
      test_reset;
      test_single_beat("silu",
         {20'hE0000, 20'h20000, 20'h10000, 20'h00000}, 1'b0,
         {20'hFC000, 20'h1C000, 20'h0B800, 20'h00000});
      test_single_beat("sigmoid",
         {20'hE0000, 20'h20000, 20'h10000, 20'h00000}, 1'b1,
         {20'h02000, 20'h0E000, 20'h0B800, 20'h08000});
      test_single_beat("corners",
         {20'hC0000, 20'h80000, 20'h78000, 20'h40000}, 1'b0,
         {20'h00000, 20'h00000, 20'h78000, 20'h40000});
      test_stream;
      test_reset_flight;
      test_throughput;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
